// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter
//   This block shares one FFT input stream among NUM_REQ AXI-stream sources. Arbitration is
//   round-robin and happens once per frame. Each forwarded frame is tagged with the index of
//   its source, and FFT_LEN framing is enforced on the output. A new grant is issued only
//   after the FFT core reports that the previous frame has left its output.
//   Optional feature: define FFT_ARB_ZEROPAD_EN to zero-pad short frames up to FFT_LEN beats.
//   When the macro is undefined, a short frame is forwarded as-is and its source tlast ends it.
module fft_frame_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int FFT_LEN    = 8192,
  parameter int ID_WIDTH   = 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  input  logic                          fft_out_done,
  input  logic                          err_clr,
  output logic                          busy,
  output logic                          err_overflow
);

  // The counter is one bit wider than the index range so that it can hold FFT_LEN without wrapping.
  localparam int              CNT_W    = $clog2(FFT_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FFT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    XFER      = 3'd2,
`ifdef FFT_ARB_ZEROPAD_EN
    PAD       = 3'd3,
`endif
    DRAIN     = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  arb_found;
  logic [ID_WIDTH-1:0]   arb_idx;
  int                    arb_k;
  logic                  out_free;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_last;
  logic                  src_accept;

  // The granted source is selected by the frame tag. The tag does not change while a frame is in flight.
  assign src_data   = s_axis_tdata[int'(m_axis_tid)*DATA_WIDTH +: DATA_WIDTH];
  assign src_valid  = s_axis_tvalid[m_axis_tid];
  assign src_last   = s_axis_tlast[m_axis_tid];
  assign out_free   = !m_axis_tvalid || m_axis_tready;
  assign src_accept = (state == XFER) && src_valid && out_free;
  assign busy       = (state != IDLE);

  // Round-robin search starting just after the last grant. The nearest requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_k     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      arb_k = (int'(rr_ptr) + i) % NUM_REQ;
      if (s_axis_tvalid[arb_k]) begin
        arb_found = 1'b1;
        arb_idx   = ID_WIDTH'(arb_k);
      end
    end
  end

  // Only the granted source may be ready. During drain it is ready every cycle.
  always_comb begin
    s_axis_tready = '0;
    if (state == XFER)
      s_axis_tready[m_axis_tid] = out_free;
    else if (state == DRAIN)
      s_axis_tready[m_axis_tid] = 1'b1;
  end

  // Frame FSM together with the single output register and the sticky overflow flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      rr_ptr        <= ID_WIDTH'(NUM_REQ - 1);
      cnt           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      err_overflow  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (|s_axis_tvalid) state <= ARB;
        end
        ARB: begin
          if (arb_found) begin
            rr_ptr     <= arb_idx;
            m_axis_tid <= arb_idx;
            cnt        <= '0;
            state      <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (src_accept) begin
            m_axis_tdata  <= src_data;
            m_axis_tvalid <= 1'b1;
            cnt           <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              m_axis_tlast <= 1'b1;
              if (src_last) begin
                state <= WAIT_DONE;
              end else begin
                state        <= DRAIN;
                err_overflow <= 1'b1;
              end
            end else if (src_last) begin
`ifdef FFT_ARB_ZEROPAD_EN
              m_axis_tlast <= 1'b0;
              state        <= PAD;
`else
              m_axis_tlast <= 1'b1;
              state        <= WAIT_DONE;
`endif
            end else begin
              m_axis_tlast <= 1'b0;
            end
          end
        end
`ifdef FFT_ARB_ZEROPAD_EN
        PAD: begin
          if (out_free) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (cnt == LAST_CNT);
            cnt           <= cnt + 1'b1;
            if (cnt == LAST_CNT) state <= WAIT_DONE;
          end
        end
`endif
        DRAIN: begin
          if (src_valid && src_last) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!m_axis_tvalid && fft_out_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (err_clr) err_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Testbench for fft_frame_arbiter. It runs with a short FFT_LEN so that every frame finishes quickly.
// A behavioural source model feeds the inputs and a simple FFT-done model closes each frame.
module tb_fft_frame_arbiter;
  localparam int NR  = 2;
  localparam int DW  = 16;
  localparam int LEN = 16;
  localparam int IDW = 1;
`ifdef FFT_ARB_ZEROPAD_EN
  localparam bit PADDING = 1'b1;
`else
  localparam bit PADDING = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR*DW-1:0] s_tdata;
  logic [NR-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tlast, m_tready;
  logic [IDW-1:0]   m_tid;
  logic             fft_out_done, err_clr, busy, err_overflow;

  fft_frame_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FFT_LEN(LEN), .ID_WIDTH(IDW)) dut (
    .aclk(clk), .areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .m_axis_tid(m_tid), .fft_out_done(fft_out_done), .err_clr(err_clr),
    .busy(busy), .err_overflow(err_overflow)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           l;
    logic [DW-1:0]  d;
  } beat_t;

  typedef struct {
    int src;
    int len;
    bit tog;
    int exp_beats;
    bit exp_err;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    src_len[NR], src_rep[NR], src_idx[NR], src_frame[NR];
  bit    acc[NR];
  bit    toggle, done_arm, onehot_bad;
  int    done_cnt;
  beat_t cap_q[$];
  vec_t  vecs[7];

  function automatic logic [DW-1:0] pat(int s, int f, int b);
    return DW'(s * 4096 + f * 256 + b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NR; i++) begin
      s_tvalid[i]          = (src_rep[i] > 0);
      s_tdata[i*DW +: DW]  = (src_rep[i] > 0) ? pat(i, src_frame[i], src_idx[i]) : '0;
      s_tlast[i]           = (src_rep[i] > 0) && (src_idx[i] == src_len[i] - 1);
    end
  endtask

  // One clock. Handshakes are observed on the falling edge, and inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) acc[i] = s_tvalid[i] & s_tready[i];
    if (!$onehot0(s_tready)) onehot_bad = 1'b1;
    if (done_arm && !busy) done_arm = 1'b0;
    if (m_tvalid && m_tready) begin
      cap_q.push_back('{id: m_tid, l: m_tlast, d: m_tdata});
      if (m_tlast) done_arm = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        src_idx[i]++;
        if (src_idx[i] == src_len[i]) begin
          src_idx[i] = 0;
          src_frame[i]++;
          if (src_rep[i] > 0) src_rep[i]--;
        end
      end
    end
    fft_out_done = 1'b0;
    if (done_arm) begin
      done_cnt++;
      if (done_cnt % 4 == 3) fft_out_done = 1'b1;
    end else begin
      done_cnt = 0;
    end
    m_tready = toggle ? ~m_tready : 1'b1;
    drive_src();
  endtask

  task automatic run_frame(input int s, input int len, input bit tog, input int exp_beats,
                           input bit exp_err, input string name);
    int  f;
    bit  fin;
    int  nb;
    beat_t exp_b;
    cap_q.delete();
    toggle = tog;
    f = src_frame[s];
    src_len[s] = len;
    src_idx[s] = 0;
    src_rep[s] = 1;
    drive_src();
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      tick();
      if (cap_q.size() > 0 && cap_q[$].l && !busy && src_rep[s] == 0) fin = 1'b1;
    end
    chk({name, " completed"}, 64'(fin), 64'd1);
    chk({name, " beat count"}, 64'(cap_q.size()), 64'(exp_beats));
    nb = (cap_q.size() < exp_beats) ? cap_q.size() : exp_beats;
    for (int b = 0; b < nb; b++) begin
      exp_b.id = IDW'(s);
      exp_b.l  = (b == exp_beats - 1);
      exp_b.d  = (b < len) ? pat(s, f, b) : '0;
      chk($sformatf("%s beat%0d {id,last,data}", name, b), 64'(cap_q[b]), 64'(exp_b));
    end
    chk({name, " err_overflow"}, 64'(err_overflow), 64'(exp_err));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk({name, " err after clr"}, 64'(err_overflow), 64'd0);
    toggle = 1'b0;
  endtask

  initial begin
    int   base[NR];
    bit   fin;
    beat_t exp_b;

    // The table of single-source frames holds hand-computed beat counts for FFT_LEN=16.
    vecs[0] = '{src: 0, len: 16, tog: 1'b0, exp_beats: 16, exp_err: 1'b0};
    vecs[1] = '{src: 1, len: 16, tog: 1'b1, exp_beats: 16, exp_err: 1'b0};
    vecs[2] = '{src: 0, len: 16, tog: 1'b1, exp_beats: 16, exp_err: 1'b0};
    vecs[3] = '{src: 1, len: 5,  tog: 1'b0, exp_beats: PADDING ? 16 : 5, exp_err: 1'b0};
    vecs[4] = '{src: 0, len: 1,  tog: 1'b1, exp_beats: PADDING ? 16 : 1, exp_err: 1'b0};
    vecs[5] = '{src: 0, len: 24, tog: 1'b0, exp_beats: 16, exp_err: 1'b1};
    vecs[6] = '{src: 1, len: 17, tog: 1'b1, exp_beats: 16, exp_err: 1'b1};

    rst = 1'b1;
    err_clr = 1'b0;
    fft_out_done = 1'b0;
    m_tready = 1'b1;
    toggle = 1'b0;
    done_arm = 1'b0;
    done_cnt = 0;
    onehot_bad = 1'b0;
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0; src_rep[i] = 0; src_idx[i] = 0; src_frame[i] = 0;
    end
    drive_src();
    tick();
    tick();
    chk("reset outputs", 64'({m_tdata, m_tvalid, m_tlast, m_tid, s_tready, err_overflow}), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++)
      run_frame(vecs[v].src, vecs[v].len, vecs[v].tog, vecs[v].exp_beats, vecs[v].exp_err,
                $sformatf("vec%0d", v));

    // Apply an asynchronous reset in the middle of a frame, then run a clean frame from beat 0.
    cap_q.delete();
    src_len[0] = 16; src_idx[0] = 0; src_rep[0] = 1;
    drive_src();
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      tick();
      if (cap_q.size() >= 5) fin = 1'b1;
    end
    chk("midframe reached beat 5", 64'(fin), 64'd1);
    rst = 1'b1;
    #1;
    chk("midframe reset outputs", 64'({m_tdata, m_tvalid, m_tlast, m_tid, s_tready, err_overflow}), 64'd0);
    chk("midframe reset busy", 64'(busy), 64'd0);
    src_rep[0] = 0; src_idx[0] = 0; src_frame[0]++;
    done_arm = 1'b0;
    drive_src();
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_frame(1, 16, 1'b0, 16, 1'b0, "after reset src1");

    // Reset again so the round-robin pointer starts from NUM_REQ-1, then keep both sources streaming.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cap_q.delete();
    onehot_bad = 1'b0;
    for (int i = 0; i < NR; i++) begin
      base[i] = src_frame[i];
      src_len[i] = 16; src_idx[i] = 0; src_rep[i] = 2;
    end
    drive_src();
    fin = 1'b0;
    for (int c = 0; c < 800 && !fin; c++) begin
      tick();
      if (cap_q.size() >= 64 && !busy && src_rep[0] == 0 && src_rep[1] == 0) fin = 1'b1;
    end
    chk("rr completed", 64'(fin), 64'd1);
    chk("rr beat count", 64'(cap_q.size()), 64'd64);
    for (int b = 0; b < 64 && b < cap_q.size(); b++) begin
      exp_b.id = IDW'((b / 16) % 2);
      exp_b.l  = ((b % 16) == 15);
      exp_b.d  = pat((b / 16) % 2, base[(b / 16) % 2] + (b / 32), b % 16);
      chk($sformatf("rr beat%0d {id,last,data}", b), 64'(cap_q[b]), 64'(exp_b));
    end
    chk("rr ready onehot violation", 64'(onehot_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
